ga_telemetry_framer: RTL

Parametrised progress reporter for the morphologic genetic-algorithm core. It samples the GA's best error and best individual on every generation strobe and maintains a generation counter, stall detector and finish flag. Selected snapshots are serialised into byte frames over a valid/ready stream that feeds the serial transmitter. It replaces the fixed counter-plus-individual dump with decimated, event-driven, framed reporting.

---
 rtl/ga_telemetry_pkg.sv | 40 ++++
 rtl/ga_frame_serializer.sv | 69 ++++++
 rtl/ga_telemetry_framer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ga_telemetry_pkg.sv
// Shared constants, FSM encoding and frame-size helpers for the GA telemetry framer.
// Optional feature: define GA_TELEMETRY_CHECKSUM_EN to append an XOR checksum byte to each frame.
package ga_telemetry_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Bit positions inside the FLAGS byte
    localparam int unsigned FLAG_FINISH_BIT  = 0;
    localparam int unsigned FLAG_STALLED_BIT = 1;

    // SYNC + SEQ + FLAGS
    localparam int unsigned HDR_BYTES = 3;

`ifdef GA_TELEMETRY_CHECKSUM_EN
    localparam int unsigned CHK_BYTES = 1;
`else
    localparam int unsigned CHK_BYTES = 0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } fsm_state_e;

    // Whole bytes needed to carry a field of the given bit width
    function automatic int unsigned bytes_for(input int unsigned width);
        return (width + 32'd7) / 32'd8;
    endfunction

    // Total frame length in bytes, including the optional CHK byte
    function automatic int unsigned frame_len(input int unsigned cw,
                                              input int unsigned ew,
                                              input int unsigned iw);
        return HDR_BYTES + bytes_for(cw) + bytes_for(ew) + bytes_for(iw) + CHK_BYTES;
    endfunction

    localparam int unsigned FRAME_LEN_DEFAULT = frame_len(32, 5, 32);

endpackage

// File: rtl/ga_frame_serializer.sv
// Shift-buffer byte serializer with a valid/ready output stage.
// With GA_TELEMETRY_CHECKSUM_EN defined, the last byte is replaced by the XOR of all earlier bytes.
module ga_frame_serializer
    import ga_telemetry_pkg::*;
#(
    parameter int unsigned FrameBytes = FRAME_LEN_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic [FrameBytes*8-1:0] i_frame,
    input  logic                    i_ready,
    output logic [7:0]              o_data,
    output logic                    o_valid,
    output logic                    o_last_hs_c
);

    localparam int unsigned BufWidth = FrameBytes * 8;
    localparam int unsigned IdxWidth = $clog2(FrameBytes);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(FrameBytes - 1);
`ifdef GA_TELEMETRY_CHECKSUM_EN
    localparam logic [IdxWidth-1:0] ChkPrevIdx = IdxWidth'(FrameBytes - 2);
    logic [7:0] r_chk;
`endif

    logic [BufWidth-1:0] r_buf;
    logic [IdxWidth-1:0] r_idx;
    logic                r_valid;
    logic [7:0]          w_byte;
    logic                w_hs;

    assign w_byte      = r_buf[BufWidth-1 -: 8];
    assign w_hs        = r_valid && i_ready;
    assign o_last_hs_c = w_hs && (r_idx == LastIdx);
    assign o_data      = w_byte;
    assign o_valid     = r_valid;

    // Load a whole frame, then shift out one byte per accepted handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
`ifdef GA_TELEMETRY_CHECKSUM_EN
            r_chk   <= '0;
`endif
        end else if (i_load) begin
            r_buf   <= i_frame;
            r_idx   <= '0;
            r_valid <= 1'b1;
`ifdef GA_TELEMETRY_CHECKSUM_EN
            r_chk   <= '0;
`endif
        end else if (w_hs) begin
            r_buf <= {r_buf[BufWidth-9:0], 8'h00};
            r_idx <= r_idx + IdxWidth'(1);
            if (r_idx == LastIdx) begin
                r_valid <= 1'b0;
            end
`ifdef GA_TELEMETRY_CHECKSUM_EN
            r_chk <= r_chk ^ w_byte;
            if (r_idx == ChkPrevIdx) begin
                r_buf[BufWidth-1 -: 8] <= r_chk ^ w_byte;
            end
`endif
        end
    end

endmodule

// File: rtl/ga_telemetry_framer.sv
// GA progress reporter: generation/stall/finish tracking, event-driven snapshots, framed byte stream.
// Optional feature: GA_TELEMETRY_CHECKSUM_EN appends an XOR checksum byte to every frame.
module ga_telemetry_framer
    import ga_telemetry_pkg::*;
#(
    parameter int unsigned ErrorWidth      = 5,
    parameter int unsigned IndividualWidth = 32,
    parameter int unsigned CounterWidth    = 32,
    parameter int unsigned DecimationLog2  = 4,
    parameter int unsigned StallLimit      = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cycle,
    input  logic [ErrorWidth-1:0]      best_error,
    input  logic [IndividualWidth-1:0] best_individual,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CounterWidth-1:0]    generation,
    output logic                       stalled,
    output logic                       finish,
    output logic [7:0]                 dropped
);

    localparam int unsigned FieldCw    = bytes_for(CounterWidth) * 8;
    localparam int unsigned FieldEw    = bytes_for(ErrorWidth) * 8;
    localparam int unsigned FieldIw    = bytes_for(IndividualWidth) * 8;
    localparam int unsigned FrameBytes = frame_len(CounterWidth, ErrorWidth, IndividualWidth);
    localparam int unsigned FrameWidth = FrameBytes * 8;
    localparam int unsigned StallWidth = $clog2(StallLimit + 1);
    localparam logic [StallWidth-1:0]   StallMax = StallWidth'(StallLimit);
    localparam logic [CounterWidth-1:0] DecMask  =
        (CounterWidth'(1) << DecimationLog2) - CounterWidth'(1);

    logic [CounterWidth-1:0]    r_gen;
    logic [StallWidth-1:0]      r_stall_cnt;
    logic                       r_stalled;
    logic                       r_finish;
    logic [ErrorWidth-1:0]      r_rec_err;
    logic [7:0]                 r_dropped;
    logic [7:0]                 r_seq;
    logic                       r_slot_full;
    logic [CounterWidth-1:0]    r_slot_gen;
    logic [ErrorWidth-1:0]      r_slot_err;
    logic [IndividualWidth-1:0] r_slot_ind;
    logic [7:0]                 r_slot_flags;
    fsm_state_e                 r_state;

    logic                    w_strobe;
    logic [CounterWidth-1:0] w_gen_next;
    logic                    w_improve;
    logic [StallWidth-1:0]   w_stall_next;
    logic                    w_stalled_next;
    logic                    w_finish_next;
    logic [7:0]              w_flags;
    logic                    w_event;
    logic                    w_load;
    logic                    w_last_hs;
    logic [FrameWidth-1:0]   w_frame;
    fsm_state_e              w_next_state;

    assign w_strobe   = cycle && !r_finish;
    assign generation = r_gen;
    assign stalled    = r_stalled;
    assign finish     = r_finish;
    assign dropped    = r_dropped;

    // Per-strobe next values and report-event decision
    always_comb begin
        w_gen_next   = r_gen + CounterWidth'(1);
        w_improve    = best_error < r_rec_err;
        w_stall_next = r_stall_cnt;
        if (w_improve) begin
            w_stall_next = '0;
        end else if (r_stall_cnt != StallMax) begin
            w_stall_next = r_stall_cnt + StallWidth'(1);
        end
        w_stalled_next = (w_stall_next == StallMax);
        w_finish_next  = (best_error == '0);
        w_flags        = '0;
        w_flags[FLAG_STALLED_BIT] = w_stalled_next;
        w_flags[FLAG_FINISH_BIT]  = w_finish_next;
        w_event = w_strobe && (((w_gen_next & DecMask) == '0) || w_improve ||
                               w_finish_next || (w_stalled_next && !r_stalled));
    end

    // Generation counter, stall detector, recorded error and sticky finish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gen       <= '0;
            r_stall_cnt <= '0;
            r_stalled   <= 1'b0;
            r_finish    <= 1'b0;
            r_rec_err   <= '1;
        end else if (w_strobe) begin
            r_gen       <= w_gen_next;
            r_stall_cnt <= w_stall_next;
            r_stalled   <= w_stalled_next;
            if (w_improve) begin
                r_rec_err <= best_error;
            end
            if (w_finish_next) begin
                r_finish <= 1'b1;
            end
        end
    end

    // Pending snapshot slot; an unconsumed snapshot that gets overwritten counts as dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_full  <= 1'b0;
            r_slot_gen   <= '0;
            r_slot_err   <= '0;
            r_slot_ind   <= '0;
            r_slot_flags <= '0;
            r_dropped    <= '0;
        end else if (w_event) begin
            r_slot_full  <= 1'b1;
            r_slot_gen   <= w_gen_next;
            r_slot_err   <= best_error;
            r_slot_ind   <= best_individual;
            r_slot_flags <= w_flags;
            if (r_slot_full && !w_load && (r_dropped != 8'hFF)) begin
                r_dropped <= r_dropped + 8'd1;
            end
        end else if (w_load) begin
            r_slot_full <= 1'b0;
        end
    end

    // Frame sequence number advances once per loaded frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq <= '0;
        end else if (w_load) begin
            r_seq <= r_seq + 8'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_event || r_slot_full) w_next_state = ST_LOAD;
            ST_LOAD: w_next_state = ST_SEND;
            ST_SEND: begin
                if (w_last_hs) begin
                    w_next_state = (w_event || r_slot_full) ? ST_LOAD : ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_load = 1'b0;
        if (r_state == ST_LOAD) begin
            w_load = 1'b1;
        end
    end

    // Frame image, MSB byte first; the CHK position (if any) is left zero for the serializer
    always_comb begin
        w_frame = FrameWidth'({SYNC_BYTE, r_seq, r_slot_flags, FieldCw'(r_slot_gen),
                               FieldEw'(r_slot_err), FieldIw'(r_slot_ind)}) << (CHK_BYTES * 8);
    end

    ga_frame_serializer #(
        .FrameBytes (FrameBytes)
    ) u_serializer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_frame     (w_frame),
        .i_ready     (out_ready),
        .o_data      (out_data),
        .o_valid     (out_valid),
        .o_last_hs_c (w_last_hs)
    );

endmodule
